// File: rtl/pc_sequencer_if.sv
// Control and address bundle between decode, the program sequencer and the
// instruction memory. Decode drives the strobes and reads back PC and status.
interface pc_sequencer_if #(
  parameter int IM_LENGTH  = 9,
  parameter int LOOP_CNT_W = 8
);
  logic                  ENABLE;
  logic                  BRANCH;
  logic                  CALL;
  logic                  RET;
  logic [IM_LENGTH-1:0]  BR_TARGET;
  logic                  LOOP_SET;
  logic [IM_LENGTH-1:0]  LOOP_END;
  logic [LOOP_CNT_W-1:0] LOOP_COUNT;
  logic [IM_LENGTH-1:0]  PC;
  logic                  LOOP_ACTIVE;
  logic                  STK_OVF;
  logic                  STK_UNF;

  modport master (
    output ENABLE, BRANCH, CALL, RET, BR_TARGET, LOOP_SET, LOOP_END, LOOP_COUNT,
    input  PC, LOOP_ACTIVE, STK_OVF, STK_UNF
  );

  modport slave (
    input  ENABLE, BRANCH, CALL, RET, BR_TARGET, LOOP_SET, LOOP_END, LOOP_COUNT,
    output PC, LOOP_ACTIVE, STK_OVF, STK_UNF
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program sequencer: owns the PC and selects the next PC from return-stack
// pop, call, taken branch, hardware loop-back or plain increment.
module pc_sequencer #(
  parameter int IM_LENGTH   = 9,
  parameter int STACK_DEPTH = 4,
  parameter int STACK_PTR_W = 3,
  parameter int LOOP_CNT_W  = 8
) (
  input logic            CLK,
  input logic            RESET,
  pc_sequencer_if.slave  bus
);

  // Entry index width; a single-entry stack still needs a one-bit index.
  localparam int STK_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [STACK_PTR_W-1:0] SP_FULL = STACK_PTR_W'(STACK_DEPTH);
  localparam logic [STACK_PTR_W-1:0] SP_ONE  = STACK_PTR_W'(1);
  localparam logic [LOOP_CNT_W-1:0]  CNT_ONE = LOOP_CNT_W'(1);

  logic [IM_LENGTH-1:0]   pc_reg, pc_next;
  logic [STACK_PTR_W-1:0] sp_reg, sp_next;
  logic                   loop_active_reg, loop_active_next;
  logic [LOOP_CNT_W-1:0]  loop_cnt_reg, loop_cnt_next;
  logic [IM_LENGTH-1:0]   loop_start_reg, loop_start_next;
  logic [IM_LENGTH-1:0]   loop_end_reg, loop_end_next;
  logic                   stk_ovf_reg, stk_ovf_next;
  logic                   stk_unf_reg, stk_unf_next;

  logic [IM_LENGTH-1:0]   pc_inc;
  logic                   push_en;
  logic [STK_IDX_W-1:0]   push_idx;
  logic [STK_IDX_W-1:0]   pop_idx;
  logic [IM_LENGTH-1:0]   stack_rd [STACK_DEPTH];

  // Wraps naturally modulo 2^IM_LENGTH.
  assign pc_inc   = pc_reg + IM_LENGTH'(1);
  assign push_idx = STK_IDX_W'(sp_reg);
  assign pop_idx  = STK_IDX_W'(sp_reg - SP_ONE);

  // Return stack: one register per entry, written only on a successful push.
  // Contents are not reset; an entry is only read after it has been pushed.
  for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
    logic [IM_LENGTH-1:0] entry_reg;

    // Capture the return address when this entry is the push slot.
    always_ff @(posedge CLK) begin
      if (push_en && (push_idx == STK_IDX_W'(gi))) begin
        entry_reg <= pc_inc;
      end
    end

    assign stack_rd[gi] = entry_reg;
  end

  // Next-state selection: RET > CALL > BRANCH > loop-back > PC+1, with
  // LOOP_SET evaluated alongside and suppressing a loop-back in the same cycle.
  always_comb begin
    pc_next          = pc_reg;
    sp_next          = sp_reg;
    loop_active_next = loop_active_reg;
    loop_cnt_next    = loop_cnt_reg;
    loop_start_next  = loop_start_reg;
    loop_end_next    = loop_end_reg;
    stk_ovf_next     = stk_ovf_reg;
    stk_unf_next     = stk_unf_reg;
    push_en          = 1'b0;

    if (bus.ENABLE) begin
      pc_next = pc_inc;

      if (bus.RET) begin
        // A CALL arriving together with RET is silently dropped.
        if (sp_reg != '0) begin
          pc_next = stack_rd[pop_idx];
          sp_next = sp_reg - SP_ONE;
        end else begin
          stk_unf_next = 1'b1;
        end
      end else if (bus.CALL) begin
        // A call with a full stack is dropped and falls through to PC+1.
        if (sp_reg < SP_FULL) begin
          push_en = 1'b1;
          pc_next = bus.BR_TARGET;
          sp_next = sp_reg + SP_ONE;
        end else begin
          stk_ovf_next = 1'b1;
        end
      end else if (bus.BRANCH) begin
        pc_next = bus.BR_TARGET;
      end else if (loop_active_reg && (pc_reg == loop_end_reg) && !bus.LOOP_SET) begin
        if (loop_cnt_reg > CNT_ONE) begin
          pc_next       = loop_start_reg;
          loop_cnt_next = loop_cnt_reg - CNT_ONE;
        end else begin
          // Last pass through the body: fall out of the loop.
          loop_cnt_next    = '0;
          loop_active_next = 1'b0;
        end
      end

      if (bus.LOOP_SET) begin
        loop_start_next  = pc_inc;
        loop_end_next    = bus.LOOP_END;
        loop_cnt_next    = bus.LOOP_COUNT;
        loop_active_next = (bus.LOOP_COUNT != '0);
      end
    end
  end

  // State registers; reset overrides any strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_reg          <= '0;
      sp_reg          <= '0;
      loop_active_reg <= 1'b0;
      loop_cnt_reg    <= '0;
      loop_start_reg  <= '0;
      loop_end_reg    <= '0;
      stk_ovf_reg     <= 1'b0;
      stk_unf_reg     <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      sp_reg          <= sp_next;
      loop_active_reg <= loop_active_next;
      loop_cnt_reg    <= loop_cnt_next;
      loop_start_reg  <= loop_start_next;
      loop_end_reg    <= loop_end_next;
      stk_ovf_reg     <= stk_ovf_next;
      stk_unf_reg     <= stk_unf_next;
    end
  end

  assign bus.PC          = pc_reg;
  assign bus.LOOP_ACTIVE = loop_active_reg;
  assign bus.STK_OVF     = stk_ovf_reg;
  assign bus.STK_UNF     = stk_unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized strobes, all
// checked against a queue-based behavioural model of the sequencer.
module tb_pc_sequencer;

  localparam int IM    = 9;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int MASK  = (1 << IM) - 1;

  logic CLK = 1'b0;
  logic RESET;
  logic RESET_W;

  always #5 CLK = ~CLK;

  pc_sequencer_if #(.IM_LENGTH(IM), .LOOP_CNT_W(CW)) bus ();
  pc_sequencer_if #(.IM_LENGTH(4),  .LOOP_CNT_W(CW)) bus_w ();

  pc_sequencer #(.IM_LENGTH(IM), .STACK_DEPTH(DEPTH), .STACK_PTR_W(3), .LOOP_CNT_W(CW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  // Narrow instance used only for the PC wrap-around check.
  pc_sequencer #(.IM_LENGTH(4), .STACK_DEPTH(DEPTH), .STACK_PTR_W(3), .LOOP_CNT_W(CW)) dut_w (
    .CLK   (CLK),
    .RESET (RESET_W),
    .bus   (bus_w.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_pc, m_start, m_end, m_cnt;
  bit m_act, m_ovf, m_unf;
  int m_stk[$];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    bus.ENABLE     = 1'b1;
    bus.BRANCH     = 1'b0;
    bus.CALL       = 1'b0;
    bus.RET        = 1'b0;
    bus.BR_TARGET  = '0;
    bus.LOOP_SET   = 1'b0;
    bus.LOOP_END   = '0;
    bus.LOOP_COUNT = '0;
    RESET          = 1'b0;
  endtask

  // Advance the model by the rules of the sequencer, clock the DUT, compare.
  task automatic cycle(input string tag);
    int nxt;
    int npc;
    nxt = (m_pc + 1) & MASK;
    npc = m_pc;
    if (RESET) begin
      m_pc = 0; m_stk.delete(); m_act = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else if (bus.ENABLE) begin
      npc = nxt;
      if (bus.RET) begin
        if (m_stk.size() > 0) npc = m_stk.pop_back();
        else m_unf = 1;
      end else if (bus.CALL) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back(nxt);
          npc = int'(bus.BR_TARGET);
        end else begin
          m_ovf = 1;
        end
      end else if (bus.BRANCH) begin
        npc = int'(bus.BR_TARGET);
      end else if (m_act && m_pc == m_end && !bus.LOOP_SET) begin
        if (m_cnt > 1) begin
          npc = m_start;
          m_cnt--;
        end else begin
          m_cnt = 0;
          m_act = 0;
        end
      end
      if (bus.LOOP_SET) begin
        m_start = nxt;
        m_end   = int'(bus.LOOP_END);
        m_cnt   = int'(bus.LOOP_COUNT);
        m_act   = (bus.LOOP_COUNT != 0);
      end
      m_pc = npc;
    end
    @(posedge CLK);
    #1;
    chk({tag, ".pc"},  int'(bus.PC),          m_pc);
    chk({tag, ".act"}, int'(bus.LOOP_ACTIVE), int'(m_act));
    chk({tag, ".ovf"}, int'(bus.STK_OVF),     int'(m_ovf));
    chk({tag, ".unf"}, int'(bus.STK_UNF),     int'(m_unf));
    $display("cyc t=%0t pc=%0d act=%0b ovf=%0b unf=%0b [%s]",
             $time, bus.PC, bus.LOOP_ACTIVE, bus.STK_OVF, bus.STK_UNF, tag);
  endtask

  task automatic do_reset();
    idle();
    RESET = 1'b1;
    cycle("reset");
    RESET = 1'b0;
  endtask

  initial begin
    int seq[10];
    int act[10];
    m_pc = 0; m_start = 0; m_end = 0; m_cnt = 0; m_act = 0; m_ovf = 0; m_unf = 0;
    idle();
    RESET   = 1'b1;
    RESET_W = 1'b1;
    bus_w.ENABLE = 1'b0; bus_w.BRANCH = 1'b0; bus_w.CALL = 1'b0; bus_w.RET = 1'b0;
    bus_w.BR_TARGET = '0; bus_w.LOOP_SET = 1'b0; bus_w.LOOP_END = '0; bus_w.LOOP_COUNT = '0;

    // Reset state and count-up, then stall.
    cycle("reset");
    chk("reset_pc", int'(bus.PC), 0);
    RESET_W = 1'b0;
    RESET   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle("count");
      chk("count_pc", int'(bus.PC), i);
    end
    bus.ENABLE = 1'b0;
    bus.CALL   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall_pc", int'(bus.PC), 4);
    end
    idle();

    // Wrap-around on the 4-bit instance.
    bus_w.ENABLE = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cycle("wrap");
      chk("wrap_pc", int'(bus_w.PC), i % 16);
      chk("wrap_flags", int'({bus_w.STK_OVF, bus_w.STK_UNF}), 0);
    end
    bus_w.ENABLE = 1'b0;

    // Nested calls.
    do_reset();
    for (int i = 0; i < 3; i++) cycle("run");
    bus.CALL = 1'b1; bus.BR_TARGET = 9'd20; cycle("call1"); idle();
    chk("nest_pc", int'(bus.PC), 20);
    cycle("body1");
    bus.CALL = 1'b1; bus.BR_TARGET = 9'd40; cycle("call2"); idle();
    chk("nest_pc", int'(bus.PC), 40);
    cycle("body2");
    bus.RET = 1'b1; cycle("ret2"); idle();
    chk("nest_pc", int'(bus.PC), 22);
    bus.RET = 1'b1; cycle("ret1"); idle();
    chk("nest_pc", int'(bus.PC), 4);
    bus.RET = 1'b1; cycle("ret_unf"); idle();
    chk("unf_pc", int'(bus.PC), 5);
    chk("unf_flag", int'(bus.STK_UNF), 1);

    // Overflow: fifth call falls through.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.CALL = 1'b1; bus.BR_TARGET = 9'(100 + i);
      cycle("ovf_call");
    end
    idle();
    chk("ovf_pc", int'(bus.PC), 104);
    chk("ovf_flag", int'(bus.STK_OVF), 1);
    do_reset();
    chk("flags_clear", int'({bus.STK_OVF, bus.STK_UNF}), 0);

    // Hardware loop, count 3 then count 0.
    seq = '{10, 11, 12, 10, 11, 12, 10, 11, 12, 13};
    act = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      bus.BRANCH = 1'b1; bus.BR_TARGET = 9'd9; cycle("to9"); idle();
      for (int i = 0; i < ((pass == 0) ? 10 : 4); i++) begin
        if (i == 0) begin
          bus.LOOP_SET = 1'b1; bus.LOOP_END = 9'd12;
          bus.LOOP_COUNT = (pass == 0) ? 8'd3 : 8'd0;
        end
        cycle("loop");
        idle();
        chk("loop_pc", int'(bus.PC), (pass == 0) ? seq[i] : 10 + i);
        chk("loop_act", int'(bus.LOOP_ACTIVE), (pass == 0) ? act[i] : 0);
      end
    end

    // CALL together with RET: RET wins, no flag.
    do_reset();
    bus.CALL = 1'b1; bus.BR_TARGET = 9'd50; cycle("c_call"); idle();
    bus.CALL = 1'b1; bus.RET = 1'b1; bus.BR_TARGET = 9'd70; cycle("c_callret"); idle();
    chk("callret_pc", int'(bus.PC), 1);
    chk("callret_flags", int'({bus.STK_OVF, bus.STK_UNF}), 0);

    // Branch at loop end keeps the loop armed; reset mid-loop clears it.
    do_reset();
    bus.BRANCH = 1'b1; bus.BR_TARGET = 9'd9; cycle("to9"); idle();
    bus.LOOP_SET = 1'b1; bus.LOOP_END = 9'd12; bus.LOOP_COUNT = 8'd2; cycle("arm"); idle();
    cycle("l11"); cycle("l12");
    bus.BRANCH = 1'b1; bus.BR_TARGET = 9'd30; cycle("br_end"); idle();
    chk("br_end_pc", int'(bus.PC), 30);
    chk("br_end_act", int'(bus.LOOP_ACTIVE), 1);
    bus.BRANCH = 1'b1; bus.BR_TARGET = 9'd12; cycle("back12"); idle();
    cycle("loopback");
    chk("loopback_pc", int'(bus.PC), 10);
    do_reset();
    chk("rst_loop_pc", int'(bus.PC), 0);
    chk("rst_loop_act", int'(bus.LOOP_ACTIVE), 0);

    // Randomized strobes against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      idle();
      RESET      = ($urandom_range(0, 149) == 0);
      bus.ENABLE = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 99);
      bus.RET    = (r < 10);
      bus.CALL   = (r < 3) || (r >= 10 && r < 22);
      bus.BRANCH = (r >= 22 && r < 28) || (r < 2);
      bus.BR_TARGET  = 9'($urandom_range(0, MASK));
      bus.LOOP_SET   = ($urandom_range(0, 14) == 0);
      bus.LOOP_END   = 9'((m_pc + $urandom_range(1, 6)) & MASK);
      bus.LOOP_COUNT = 8'($urandom_range(0, 4));
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
